btn_debouncer: RTL and testbench



---
 rtl/btn_pkg.sv | 33 +++
 rtl/btn_sync.sv | 24 ++
 rtl/btn_debouncer.sv | 137 +++++++++++++
 tb/tb_btn_debouncer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and timing defaults for the push-button conditioning blocks.
// State encoding is shared so that other blocks can decode debouncer state in the same terms.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_QUAL   = 3'd1,
        PRESSED      = 3'd2,
        HOLD         = 3'd3,
        REPEAT       = 3'd4,
        RELEASE_QUAL = 3'd5
    } btn_state_e;

    // Board timing at 100 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 2500000;
    localparam int unsigned DEF_HOLD_CYCLES     = 50000000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 10000000;

    // Short values for simulation
    localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;
    localparam int unsigned SIM_HOLD_CYCLES     = 8;
    localparam int unsigned SIM_REPEAT_CYCLES   = 3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous board input, with synchronous active-high reset.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
        end
    end

    assign o_sync = r_sync2;

endmodule

// File: rtl/btn_debouncer.sv
// Push-button conditioner: synchronise, debounce press/release, and derive press,
// auto-repeat and hold enables from a single shared counter.
module btn_debouncer
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic db_level,
    output logic scen,
    output logic mcen,
    output logic ccen
);

    localparam int unsigned MAX_CYCLES = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             w_btn_s;
    btn_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;

    btn_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (btn_in),
        .o_sync  (w_btn_s)
    );

    // Every state change clears the counter, so it never needs to saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_btn_s) begin
                        r_state <= PRESS_QUAL;
                        r_cnt   <= '0;
                    end
                end
                PRESS_QUAL: begin
                    if (!w_btn_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    r_state <= HOLD;
                    r_cnt   <= '0;
                end
                HOLD: begin
                    if (!w_btn_s) begin
                        r_state <= RELEASE_QUAL;
                        r_cnt   <= '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_state <= REPEAT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (!w_btn_s) begin
                        r_state <= RELEASE_QUAL;
                        r_cnt   <= '0;
                    end else if (r_cnt == REP_LAST) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                RELEASE_QUAL: begin
                    // A re-press restarts the hold timer without a new press pulse.
                    if (w_btn_s) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        db_level = 1'b0;
        scen     = 1'b0;
        mcen     = 1'b0;
        ccen     = 1'b0;
        unique case (r_state)
            PRESSED: begin
                db_level = 1'b1;
                scen     = 1'b1;
                mcen     = 1'b1;
                ccen     = 1'b1;
            end
            HOLD: begin
                db_level = 1'b1;
                ccen     = 1'b1;
            end
            REPEAT: begin
                db_level = 1'b1;
                ccen     = 1'b1;
                // Release wins over a repeat pulse landing in the same cycle.
                mcen     = w_btn_s && (r_cnt == REP_LAST);
            end
            RELEASE_QUAL: begin
                db_level = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with DEBOUNCE=4, HOLD=8, REPEAT=3.
// Cycle i means the cycle after the i-th rising edge following the stimulus change.
module tb_btn_debouncer;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic btn_in = 1'b0;
    logic db_level;
    logic scen;
    logic mcen;
    logic ccen;

    int checks   = 0;
    int failures = 0;

    btn_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .REPEAT_CYCLES   (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .db_level (db_level),
        .scen     (scen),
        .mcen     (mcen),
        .ccen     (ccen)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        btn_in = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // Outputs are compared as {db_level, scen, mcen, ccen}.
    task automatic test_reset();
        logic [3:0] got;
        rst    = 1'b1;
        btn_in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            got = {db_level, scen, mcen, ccen};
            checks++;
            if (got !== 4'b0000) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: got %b expected 0000", i, got);
            end
        end
        btn_in = 1'b0;
    endtask

    task automatic test_clean_press_long_hold();
        logic [3:0] got;
        logic [3:0] exp;
        apply_reset();
        btn_in = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            step();
            got    = {db_level, scen, mcen, ccen};
            exp[3] = (i >= 7);
            exp[2] = (i == 7);
            exp[1] = (i == 7) || ((i >= 18) && (((i - 18) % 3) == 0));
            exp[0] = (i >= 7);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL press_long_hold cycle %0d: got %b expected %b", i, got, exp);
            end
        end
    endtask

    // Continues from the long hold: release lands where a repeat pulse would fall.
    task automatic test_full_release();
        logic [3:0] got;
        logic [3:0] exp;
        btn_in = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            step();
            got    = {db_level, scen, mcen, ccen};
            exp[3] = (j < 7);
            exp[2] = 1'b0;
            exp[1] = 1'b0;
            exp[0] = (j < 3);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL full_release cycle %0d: got %b expected %b", j, got, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] got;
        logic [3:0] exp;
        apply_reset();
        btn_in = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            got    = {db_level, scen, mcen, ccen};
            exp[3] = (i >= 12);
            exp[2] = (i == 12);
            exp[1] = (i == 12);
            exp[0] = (i >= 12);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL bounce cycle %0d: got %b expected %b", i, got, exp);
            end
            if (i == 2) btn_in = 1'b0;
            if (i == 5) btn_in = 1'b1;
        end
    endtask

    task automatic test_release_glitch();
        logic [3:0] got;
        logic [3:0] exp;
        apply_reset();
        btn_in = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            got    = {db_level, scen, mcen, ccen};
            exp[3] = (i >= 7);
            exp[2] = (i == 7);
            exp[1] = (i == 7) || (i == 25) || (i == 28);
            exp[0] = (i >= 7) && (i != 13) && (i != 14);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL release_glitch cycle %0d: got %b expected %b", i, got, exp);
            end
            if (i == 10) btn_in = 1'b0;
            if (i == 12) btn_in = 1'b1;
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic [3:0] got;
        logic [3:0] exp;
        apply_reset();
        btn_in = 1'b1;
        repeat (20) step();
        checks++;
        if (ccen !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_ccen: got %b expected 1", ccen);
        end
        rst = 1'b1;
        step();
        got = {db_level, scen, mcen, ccen};
        checks++;
        if (got !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_repeat: got %b expected 0000", got);
        end
        rst = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            step();
            got    = {db_level, scen, mcen, ccen};
            exp[3] = (j >= 7);
            exp[2] = (j == 7);
            exp[1] = (j == 7);
            exp[0] = (j >= 7);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL requalify_after_reset cycle %0d: got %b expected %b", j, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press_long_hold();
        test_full_release();
        test_bounce();
        test_release_glitch();
        test_reset_mid_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
